// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_W = 32;
  localparam logic [5:0] DIV_ITER_LAST = 6'd31;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration on the packed {remainder, quotient} register.
module div_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] remQuo,
  input  logic [W-1:0]   divisor,
  output logic [2*W-1:0] remQuoNext
);

  logic [W:0]   partial;
  logic [W-1:0] diff;
  logic         fits;

  // Shifted remainder takes the next dividend bit from the quotient MSB.
  assign partial = remQuo[2*W-1:W-1];
  assign fits    = partial >= {1'b0, divisor};
  // When the divisor fits, the true difference is below 2^W, so low bits suffice.
  assign diff    = partial[W-1:0] - divisor;

  assign remQuoNext = fits ? {diff, remQuo[W-2:0], 1'b1}
                           : {partial[W-1:0], remQuo[W-2:0], 1'b0};

endmodule

// File: rtl/div_unit.sv
// DIV/DIVU execute-stage divider with pipeline stall; 33-cycle latency.
// Optional macro DIV_ZERO_FASTPATH_EN: divide-by-zero completes straight from IDLE.
module div_unit #(
  parameter int DIV_W = div_pkg::DIV_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startE,
  input  logic               signedE,
  input  logic [DIV_W-1:0]   aE,
  input  logic [DIV_W-1:0]   bE,
  input  logic               annulE,
  output logic               div_stallE,
  output logic [2*DIV_W-1:0] div_resultE,
  output logic               div_readyE
);
  import div_pkg::*;

  div_state_t         state;
  logic [5:0]         iterCnt;
  logic [2*DIV_W-1:0] remQuo;
  logic [2*DIV_W-1:0] remQuoNext;
  logic [DIV_W-1:0]   divisor;
  logic [DIV_W-1:0]   absA;
  logic [DIV_W-1:0]   absB;
  logic [DIV_W-1:0]   rawRem;
  logic [DIV_W-1:0]   rawQuo;
  logic               negQuo;
  logic               negRem;
  logic               zeroFast;

  assign absA = (signedE && aE[DIV_W-1]) ? -aE : aE;
  assign absB = (signedE && bE[DIV_W-1]) ? -bE : bE;

`ifdef DIV_ZERO_FASTPATH_EN
  assign zeroFast = (bE == '0);
`else
  assign zeroFast = 1'b0;
`endif

  div_step #(.W(DIV_W)) u_step (
    .remQuo     (remQuo),
    .divisor    (divisor),
    .remQuoNext (remQuoNext)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      iterCnt <= '0;
      remQuo  <= '0;
      divisor <= '0;
      negQuo  <= 1'b0;
      negRem  <= 1'b0;
    end else if (annulE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (startE) begin
            divisor <= absB;
            negQuo  <= signedE && (aE[DIV_W-1] ^ bE[DIV_W-1]);
            negRem  <= signedE && aE[DIV_W-1];
            iterCnt <= '0;
            if (zeroFast) begin
              // Exactly what 32 iterations against a zero divisor would leave.
              remQuo <= {absA, {DIV_W{1'b1}}};
              state  <= DONE;
            end else begin
              remQuo <= {{DIV_W{1'b0}}, absA};
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          remQuo <= remQuoNext;
          if (iterCnt == DIV_ITER_LAST) begin
            state <= DONE;
          end else begin
            iterCnt <= iterCnt + 6'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rawRem = remQuo[2*DIV_W-1:DIV_W];
  assign rawQuo = remQuo[DIV_W-1:0];

  assign div_resultE = {negRem ? -rawRem : rawRem, negQuo ? -rawQuo : rawQuo};
  assign div_readyE  = (state == DONE) && !annulE;
  assign div_stallE  = !annulE && (((state == IDLE) && startE) || (state == BUSY));

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized DIV/DIVU against an arithmetic model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        startE;
  logic        signedE;
  logic [31:0] aE;
  logic [31:0] bE;
  logic        annulE;
  logic        div_stallE;
  logic [63:0] div_resultE;
  logic        div_readyE;

  int nPass   = 0;
  int nChecks = 0;

  logic        cmpEn     = 1'b0;
  logic        expStall  = 1'b0;
  logic        expReady  = 1'b0;
  logic [63:0] expResult = '0;
  logic        holdValid = 1'b0;
  string       opName    = "reset";

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .startE      (startE),
    .signedE     (signedE),
    .aE          (aE),
    .bE          (bE),
    .annulE      (annulE),
    .div_stallE  (div_stallE),
    .div_resultE (div_resultE),
    .div_readyE  (div_readyE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s/%s: got %h expected %h", opName, nm, act, exp);
  endtask

  // Quotient truncates toward zero, remainder follows the dividend's sign.
  function automatic logic [63:0] model(logic s, logic [31:0] a, logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = (s && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(negedge clk) begin
    if (cmpEn) begin
      check("stall", {63'd0, div_stallE}, {63'd0, expStall});
      check("ready", {63'd0, div_readyE}, {63'd0, expReady});
      if (expReady || holdValid) check("result", div_resultE, expResult);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(string nm, logic s, logic [31:0] a, logic [31:0] b, logic [63:0] res);
    int lat;
    lat = 33;
`ifdef DIV_ZERO_FASTPATH_EN
    if (b == 0) lat = 1;
`endif
    opName    = nm;
    startE    = 1'b1;
    signedE   = s;
    aE        = a;
    bE        = b;
    holdValid = 1'b0;
    expResult = res;
    for (int c = 0; c <= lat; c++) begin
      expStall = (c < lat);
      expReady = (c == lat);
      step();
    end
    startE    = 1'b0;
    expStall  = 1'b0;
    expReady  = 1'b0;
    holdValid = 1'b1;
  endtask

  task automatic idle(int n);
    startE   = 1'b0;
    expStall = 1'b0;
    expReady = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    rst = 1'b1; startE = 1'b0; signedE = 1'b0; aE = '0; bE = '0; annulE = 1'b0;
    expResult = '0; holdValid = 1'b1; cmpEn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    opName = "model";
    check("m_100_7",   model(1'b0, 32'd100, 32'd7),              64'h00000002_0000000E);
    check("m_neg7_2",  model(1'b1, 32'hFFFF_FFF9, 32'd2),        64'hFFFFFFFF_FFFFFFFD);
    check("m_ovf",     model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h00000000_80000000);
    check("m_5_0",     model(1'b0, 32'd5, 32'd0),                64'h00000005_FFFFFFFF);
    check("m_7_neg2",  model(1'b1, 32'd7, 32'hFFFF_FFFE),        64'h00000001_FFFFFFFD);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    idle(2);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
    idle(1);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
    idle(1);

    // Annul at cycle 10 of a divide, then IDLE must be visible in cycle 11.
    opName = "annul_busy"; holdValid = 1'b0;
    startE = 1'b1; signedE = 1'b0; aE = 32'd1000; bE = 32'd3;
    for (int c = 0; c < 10; c++) begin
      expStall = 1'b1; expReady = 1'b0; step();
    end
    annulE = 1'b1; expStall = 1'b0; step();
    annulE = 1'b0; startE = 1'b0; step();
    run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // Annul on the DONE cycle suppresses ready.
    opName = "annul_done"; holdValid = 1'b0;
    startE = 1'b1; signedE = 1'b0; aE = 32'd20; bE = 32'd4;
    for (int c = 0; c < 33; c++) begin
      expStall = 1'b1; expReady = 1'b0; step();
    end
    annulE = 1'b1; expStall = 1'b0; expReady = 1'b0; step();
    annulE = 1'b0; idle(1);

    // Reset at cycle 15 clears every output while the clock is still running.
    opName = "reset_mid"; holdValid = 1'b0;
    startE = 1'b1; signedE = 1'b1; aE = 32'hDEAD_BEEF; bE = 32'd12345;
    for (int c = 0; c < 15; c++) begin
      expStall = 1'b1; expReady = 1'b0; step();
    end
    rst = 1'b1; startE = 1'b0; expStall = 1'b0; expReady = 1'b0;
    expResult = '0; holdValid = 1'b1;
    step();
    rst = 1'b0;
    step();
    run_div("after_reset", 1'b1, 32'hDEAD_BEEF, 32'd12345, model(1'b1, 32'hDEAD_BEEF, 32'd12345));

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = (($urandom_range(0, 3)) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb));
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
